// File: rtl/mmio_console_pkg.sv
// Shared types and constants for the MMIO console.
//   state_e           : console FSM states (run / drain / done)
//   MMIO_SEL_BIT      : address bit that selects the MMIO region
//   FINI_CODE_DEFAULT : write data that requests simulation finish
//   byte_t            : one console character
package mmio_console_pkg;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned MMIO_SEL_BIT      = 31;
    localparam logic [31:0] FINI_CODE_DEFAULT = 32'h0002_0000;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/mmio_console_if.sv
// Bus bundle between the CPU data-bus write port / byte consumer and the console.
//   dbus_addr, dbus_wvalid, dbus_wdata : CPU write request
//   dbus_stall                          : console asks CPU to hold the write
//   tx_data, tx_valid, tx_ready         : outgoing character stream
// master: CPU/consumer side. slave: console side.
interface mmio_console_if;
    import mmio_console_pkg::*;

    logic [31:0] dbus_addr;
    logic        dbus_wvalid;
    logic [31:0] dbus_wdata;
    logic        dbus_stall;
    byte_t       tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output dbus_addr, dbus_wvalid, dbus_wdata, tx_ready,
        input  dbus_stall, tx_data, tx_valid
    );

    modport slave (
        input  dbus_addr, dbus_wvalid, dbus_wdata, tx_ready,
        output dbus_stall, tx_data, tx_valid
    );

endinterface

// File: rtl/mmio_console_fifo.sv
// Console FIFO: first-word-fall-through byte FIFO.
//   clk_i, rst_n : clock, async active-low reset
//   flush_i      : empties the FIFO on the next edge (overrides push/pop)
//   push_i/data_i: write one byte (ignored when full)
//   pop_i        : drop the head byte (ignored when empty)
//   data_o       : head byte, 0 when empty
//   full_o, empty_o, level_o : occupancy status
module mmio_console_fifo
    import mmio_console_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  byte_t                    data_i,
    input  logic                     pop_i,
    output byte_t                    data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    byte_t       mem_q [DEPTH];
    logic        do_push, do_pop;

    assign level_o = wptr_q - rptr_q;
    assign full_o  = (level_o == (AW + 1)'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            rptr_d = wptr_q;
        end else begin
            if (do_push) wptr_d = wptr_q + PtrOne;
            if (do_pop)  rptr_d = rptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/mmio_console.sv
// MMIO console and simulation-control sink on the CPU data-bus write port.
// MMIO writes (addr[31]=1) carry characters into a FIFO streamed out on tx_*;
// the finish code drains the FIFO and then raises fini_o. A full FIFO stalls
// the CPU.
//   clk_i, rst_n : clock, async active-low reset
//   bus          : mmio_console_if.slave (dbus write port + tx byte stream)
//   level_o      : FIFO occupancy
//   fini_o       : finish reached (sticky until reset)
//   timeout_o    : watchdog expired (sticky until reset)
// Optional: define MMIO_CONSOLE_TIMEOUT_EN to build the 64-bit watchdog that
// forces DONE after TIMEOUT_CYCLES cycles; otherwise timeout_o is tied 0.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter logic [31:0] FINI_CODE      = FINI_CODE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    mmio_console_if.slave          bus,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   fini_o,
    output logic                   timeout_o
);

    state_e state_q, state_d;
    logic   hit, is_fini, is_char;
    logic   fifo_full, fifo_empty, push, pop, expire;

    assign hit     = bus.dbus_wvalid && bus.dbus_addr[MMIO_SEL_BIT];
    assign is_fini = hit && (bus.dbus_wdata == FINI_CODE);
    assign is_char = hit && !is_fini;
    assign pop     = !fifo_empty && bus.tx_ready;
    assign bus.tx_valid = !fifo_empty;

    logic unused_addr;
    assign unused_addr = ^bus.dbus_addr[MMIO_SEL_BIT-1:0];

    mmio_console_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .flush_i (expire),
        .push_i  (push),
        .data_i  (bus.dbus_wdata[7:0]),
        .pop_i   (pop),
        .data_o  (bus.tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= StRun;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (is_fini)    state_d = StDrain;
            StDrain: if (fifo_empty) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StRun;
        endcase
        // Watchdog expiry beats a same-cycle finish write.
        if (expire) state_d = StDone;
    end

    // Stall looks only at full: a pop on the same edge does not admit the write.
    always_comb begin
        push           = (state_q == StRun) && is_char && !fifo_full && !expire;
        bus.dbus_stall = (state_q == StRun) && is_char && fifo_full;
        fini_o         = (state_q == StDone);
    end

`ifdef MMIO_CONSOLE_TIMEOUT_EN
    logic [63:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;

    assign expire = (state_q != StDone) && (wdog_q == 64'(TIMEOUT_CYCLES) - 64'd1);

    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q | expire;
        if (state_q != StDone) wdog_d = wdog_q + 64'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expire         = 1'b0;
    assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_console.sv
module tb_mmio_console;
    import mmio_console_pkg::*;

    localparam int unsigned DEPTH      = 16;
    localparam int unsigned TB_TIMEOUT = 100;

    logic       clk;
    logic       rst_n;
    logic [4:0] level;
    logic       fini;
    logic       timeout;

    int    checks = 0;
    int    errors = 0;
    byte_t exp_q[$];

    mmio_console_if bus_if ();

    mmio_console #(
        .DEPTH          (DEPTH),
        .FINI_CODE      (32'h0002_0000),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .level_o   (level),
        .fini_o    (fini),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+2, so at negedge they are stable for the coming edge.
    always @(negedge clk) begin
        if (rst_n && bus_if.tx_valid && bus_if.tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got byte %02h, none expected", bus_if.tx_data);
            end else begin
                byte_t e;
                e = exp_q.pop_front();
                if (bus_if.tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_order: got %02h expected %02h", bus_if.tx_data, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1;
        rst_n              = 1'b0;
        bus_if.dbus_addr   = '0;
        bus_if.dbus_wvalid = 1'b0;
        bus_if.dbus_wdata  = '0;
        bus_if.tx_ready    = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // One-cycle write; checks the combinational stall before the edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input bit exp_stall, input bit exp_push, input string name);
        bus_if.dbus_addr   = addr;
        bus_if.dbus_wdata  = data;
        bus_if.dbus_wvalid = 1'b1;
        #1;
        checks++;
        if (bus_if.dbus_stall !== exp_stall) begin
            errors++;
            $display("FAIL %s_stall: got %b expected %b", name, bus_if.dbus_stall, exp_stall);
        end
        if (exp_push) exp_q.push_back(data[7:0]);
        cyc();
        bus_if.dbus_wvalid = 1'b0;
    endtask

    task automatic check_level(input logic [4:0] exp, input string name);
        checks++;
        if (level !== exp) begin
            errors++;
            $display("FAIL %s_level: got %0d expected %0d", name, level, exp);
        end
    endtask

    task automatic check_fini(input logic exp, input string name);
        checks++;
        if (fini !== exp) begin
            errors++;
            $display("FAIL %s_fini: got %b expected %b", name, fini, exp);
        end
    endtask

    task automatic drain(input string name);
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d bytes still expected, 0 required", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({level, bus_if.tx_valid, bus_if.tx_data, fini, timeout, bus_if.dbus_stall}
            !== 17'h0) begin
            errors++;
            $display("FAIL reset_state: level=%0d valid=%b data=%02h fini=%b to=%b stall=%b",
                     level, bus_if.tx_valid, bus_if.tx_data, fini, timeout, bus_if.dbus_stall);
        end
    endtask

    task automatic test_hello();
        do_reset();
        bus_if.tx_ready = 1'b1;
        wr(32'h8000_0000, 32'h0000_0048, 1'b0, 1'b1, "hello_h");
        checks++;
        if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'h48) begin
            errors++;
            $display("FAIL hello_latency: valid=%b data=%02h expected 1/48",
                     bus_if.tx_valid, bus_if.tx_data);
        end
        wr(32'h8000_0000, 32'h0000_0069, 1'b0, 1'b1, "hello_i");
        checks++;
        if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'h69) begin
            errors++;
            $display("FAIL hello_next: valid=%b data=%02h expected 1/69",
                     bus_if.tx_valid, bus_if.tx_data);
        end
        drain("hello");
        cyc();
        check_level(5'd0, "hello");
        check_fini(1'b0, "hello");
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int i = 0; i < 16; i++) wr(32'h8000_0000, 32'h30 + i, 1'b0, 1'b1, "fill");
        check_level(5'd16, "full");
        bus_if.dbus_addr   = 32'h8000_0000;
        bus_if.dbus_wdata  = 32'h0000_0040;
        bus_if.dbus_wvalid = 1'b1;
        #1;
        checks++;
        if (bus_if.dbus_stall !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: got %b expected 1", bus_if.dbus_stall);
        end
        cyc();
        check_level(5'd16, "stalled");
        bus_if.tx_ready = 1'b1;
        #1;
        checks++;
        if (bus_if.dbus_stall !== 1'b1) begin
            errors++;
            $display("FAIL pop_stall: got %b expected 1", bus_if.dbus_stall);
        end
        cyc();
        check_level(5'd15, "popped");
        bus_if.tx_ready = 1'b0;
        #1;
        checks++;
        if (bus_if.dbus_stall !== 1'b0) begin
            errors++;
            $display("FAIL retry_stall: got %b expected 0", bus_if.dbus_stall);
        end
        exp_q.push_back(8'h40);
        cyc();
        bus_if.dbus_wvalid = 1'b0;
        check_level(5'd16, "refilled");
        drain("bp");
        cyc();
        check_level(5'd0, "bp_empty");
    endtask

    task automatic test_finish();
        do_reset();
        for (int i = 0; i < 3; i++) wr(32'h8000_0000, 32'h61 + i, 1'b0, 1'b1, "fin_fill");
        wr(32'h8000_0000, 32'h0002_0000, 1'b0, 1'b0, "fin_code");
        wr(32'h8000_0000, 32'h0000_005A, 1'b0, 1'b0, "fin_drain_char");
        for (int i = 0; i < 10; i++) cyc();
        check_fini(1'b0, "fin_hold");
        check_level(5'd3, "fin_hold");
        drain("fin");
        check_fini(1'b0, "fin_lastpop");
        check_level(5'd0, "fin_lastpop");
        cyc();
        check_fini(1'b1, "fin_done");
        wr(32'h8000_0000, 32'h0000_0077, 1'b0, 1'b0, "fin_done_char");
        cyc();
        check_level(5'd0, "fin_done");
        check_fini(1'b1, "fin_sticky");
    endtask

    task automatic test_non_mmio();
        do_reset();
        wr(32'h0000_1000, 32'h0000_0041, 1'b0, 1'b0, "nonmmio");
        check_level(5'd0, "nonmmio");
        checks++;
        if (bus_if.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL nonmmio_valid: got %b expected 0", bus_if.tx_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) wr(32'h8000_0000, 32'h70 + i, 1'b0, 1'b1, "ar_fill");
        check_level(5'd5, "ar_pre");
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (level !== 5'd0 || bus_if.tx_valid !== 1'b0 || fini !== 1'b0
            || bus_if.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: level=%0d valid=%b fini=%b data=%02h expected 0/0/0/00",
                     level, bus_if.tx_valid, fini, bus_if.tx_data);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        check_level(5'd0, "ar_post");
    endtask

    task automatic test_timeout();
        do_reset();
        wr(32'h8000_0000, 32'h0000_0031, 1'b0, 1'b1, "to_char0");
        wr(32'h8000_0000, 32'h0000_0032, 1'b0, 1'b1, "to_char1");
`ifdef MMIO_CONSOLE_TIMEOUT_EN
        for (int i = 2; i < TB_TIMEOUT - 1; i++) cyc();
        checks++;
        if (timeout !== 1'b0 || fini !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: to=%b fini=%b expected 0/0", timeout, fini);
        end
        cyc();
        exp_q.delete();
        checks++;
        if (timeout !== 1'b1 || fini !== 1'b1 || bus_if.tx_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL timeout_fire: to=%b fini=%b valid=%b level=%0d expected 1/1/0/0",
                     timeout, fini, bus_if.tx_valid, level);
        end
`else
        for (int i = 0; i < 2 * TB_TIMEOUT; i++) cyc();
        checks++;
        if (timeout !== 1'b0 || fini !== 1'b0 || level !== 5'd2) begin
            errors++;
            $display("FAIL timeout_off: to=%b fini=%b level=%0d expected 0/0/2",
                     timeout, fini, level);
        end
        exp_q.delete();
`endif
    endtask

    initial begin
        rst_n              = 1'b0;
        bus_if.dbus_addr   = '0;
        bus_if.dbus_wvalid = 1'b0;
        bus_if.dbus_wdata  = '0;
        bus_if.tx_ready    = 1'b0;
        test_reset();
        test_hello();
        test_back_pressure();
        test_finish();
        test_non_mmio();
        test_async_reset();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
